seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 1000, giving the clock cycles per digit slot.
REQ-002 SHALL have parameter DEAD, default 16, giving the blanking cycles at the start of each slot; legal range is 1 <= DEAD < DIV.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port digit_we, input, 1 bit: write strobe for one BCD digit.
REQ-006 SHALL have port digit_sel, input, 2 bits: index of the digit written, 0 = least significant.
REQ-007 SHALL have port digit_in, input, 4 bits: BCD value from an upstream counter stage.
REQ-008 SHALL have port dp_in, input, 4 bits: decimal point per digit, sampled at commit.
REQ-009 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled at commit.
REQ-010 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 SHALL have port dp_n, output, 1 bit: active-low decimal point, registered.
REQ-012 SHALL have port an_n, output, 4 bits: active-low one-hot digit anode, registered.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 digit_we=1 SHALL write digit_in into shadow[digit_sel] at that edge; multiple writes to one digit keep the last value.
REQ-015 Commit SHALL copy shadow, dp_in and blank_lz into the display buffer at the edge ending the last cycle of the digit-3 slot.
REQ-016 A write at the commit edge SHALL update shadow only and appear in the next frame, not the current commit.
REQ-017 Scan order SHALL be digit 0,1,2,3, then repeat; a frame is 4*DIV cycles.
REQ-018 Slot SHALL use two states: BLANK for DEAD cycles with an_n=4'b1111, seg_n=7'h7F, dp_n=1, then DRIVE for DIV-DEAD cycles with an_n low at the slot digit only.
REQ-019 Slot cycle counter SHALL wrap at DIV-1 and advance the digit index (3 wraps to 0).
REQ-020 Encoding SHALL be standard: 0 -> 7'b1000000 ... 9 -> 7'b0010000.
REQ-021 Codes 10-15 SHALL render as a dash, 7'b0111111.
REQ-022 Leading-zero blanking: with buffered blank_lz=1, digit i (i>=1) SHALL show seg_n=7'h7F while buffer digits i..3 are all 0.
REQ-023 Digit 0 SHALL never be blanked; dp SHALL still follow dp buffer on a blanked digit.
REQ-024 frame_done SHALL be 1 exactly in the cycle after the commit edge, otherwise 0.
REQ-025 Outputs SHALL change one cycle after the state/counter transition that causes them; there is no combinational path from inputs to outputs.

Reset
REQ-026 rst_n low SHALL immediately clear shadow and the display buffer to 0, dp to 0, blank_lz buffer to 0, digit index to 0, counter to 0, state to BLANK.
REQ-027 rst_n low SHALL immediately drive an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-028 After rst_n rises, the first slot SHALL be a full digit-0 slot starting with BLANK.
REQ-029 Reset mid-frame SHALL discard uncommitted writes.

Structure
REQ-030 Package seg7_pkg SHALL hold the segment constants (digit patterns, SEG_OFF, SEG_DASH), N_DIGITS=4, and the state enum {BLANK, DRIVE}.
REQ-031 Sub-module seg7_encode SHALL implement the combinational BCD-to-segment encoding; the instantiating block registers its output.

Verification
REQ-032 With DIV=8 and DEAD=2: after reset, write 1,2,3,4 to digits 0-3 -> first frame shows all 0 (not yet committed); second frame shows digit 0 with an_n=4'b1110 and seg_n=7'b1111001 in slot cycles 2-7.
REQ-033 Write digit 2 in the same cycle as commit -> value absent in the next frame, present in the one after.
REQ-034 Buffer 0,0,5,0 with blank_lz=1 -> digits 3 and 0 per rule: digit 3 blanked, digit 2 shows 5, digit 1 shows 0, digit 0 shows 0 (7'b1000000).
REQ-035 Write 4'hC -> that digit shows 7'b0111111.
REQ-036 Assert rst_n=0 mid-DRIVE -> an_n=4'b1111 with no clock edge; after release, digit 0 BLANK for 2 cycles.
REQ-037 Run 3 frames -> frame_done pulses every 32 cycles, each 1 cycle wide, and an_n is never multi-hot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int unsigned N_DIGITS = 4;
   localparam int unsigned DIG_W    = 2;
   localparam int unsigned BCD_W    = 4;
   localparam int unsigned SEG_W    = 7;

   localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-to-segment encoder; non-BCD codes render as a dash.
// Ports:
//   i_bcd    - 4-bit digit code
//   i_blank  - force all segments off (leading-zero suppression)
//   o_seg_c  - active-low segments {g,f,e,d,c,b,a}, combinational
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [BCD_W-1:0] i_bcd,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_seg_c
);

   always_comb begin
      o_seg_c = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg_c = SEG_0;
         4'd1:    o_seg_c = SEG_1;
         4'd2:    o_seg_c = SEG_2;
         4'd3:    o_seg_c = SEG_3;
         4'd4:    o_seg_c = SEG_4;
         4'd5:    o_seg_c = SEG_5;
         4'd6:    o_seg_c = SEG_6;
         4'd7:    o_seg_c = SEG_7;
         4'd8:    o_seg_c = SEG_8;
         4'd9:    o_seg_c = SEG_9;
         default: o_seg_c = SEG_DASH;
      endcase
      if (i_blank) o_seg_c = SEG_OFF;
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with shadow/display double
// buffering, per-slot anode dead time and leading-zero blanking.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   digit_we    - write strobe: digit_in -> shadow[digit_sel]
//   digit_sel   - digit index written (0 = least significant)
//   digit_in    - BCD value
//   dp_in       - decimal points, captured at frame commit
//   blank_lz    - leading-zero blanking enable, captured at frame commit
//   seg_n       - active-low segments {g,f,e,d,c,b,a}, registered
//   dp_n        - active-low decimal point, registered
//   an_n        - active-low one-hot anode, registered
//   frame_done  - one-cycle pulse in the cycle after the commit edge
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIV  = 1000,
   parameter int unsigned DEAD = 16
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                digit_we,
   input  logic [DIG_W-1:0]    digit_sel,
   input  logic [BCD_W-1:0]    digit_in,
   input  logic [N_DIGITS-1:0] dp_in,
   input  logic                blank_lz,
   output logic [SEG_W-1:0]    seg_n,
   output logic                dp_n,
   output logic [N_DIGITS-1:0] an_n,
   output logic                frame_done
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(N_DIGITS - 1);

   logic [N_DIGITS-1:0][BCD_W-1:0] r_shadow;
   logic [N_DIGITS-1:0][BCD_W-1:0] r_buf;
   logic [N_DIGITS-1:0]            r_dp_buf;
   logic                           r_lz_buf;

   scan_state_e      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [DIG_W-1:0] r_digit, w_digit_nxt;
   logic             w_commit;

   logic [SEG_W-1:0]    r_seg_n;
   logic                r_dp_n;
   logic [N_DIGITS-1:0] r_an_n;
   logic                r_frame_done;

   logic             w_upper_zero;
   logic             w_lz_blank;
   logic [SEG_W-1:0] w_seg_c;

   // Scan state, slot counter and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_digit <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_digit <= w_digit_nxt;
      end
   end

   // Next-state: BLANK for DEAD cycles, DRIVE until the slot wraps
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_digit_nxt = r_digit;
      w_commit    = 1'b0;
      if (r_cnt == CNT_LAST) begin
         w_cnt_nxt   = '0;
         w_digit_nxt = r_digit + DIG_W'(1);
         w_commit    = (r_digit == DIG_LAST);
      end
      case (r_state)
         BLANK:   if (r_cnt == DEAD_LAST) w_state_nxt = DRIVE;
         DRIVE:   if (r_cnt == CNT_LAST)  w_state_nxt = BLANK;
         default: w_state_nxt = BLANK;
      endcase
   end

   // Shadow writes and frame-end commit; a same-edge write lands in the
   // shadow only because the buffer samples the pre-edge shadow value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_buf    <= '0;
         r_dp_buf <= '0;
         r_lz_buf <= 1'b0;
      end else begin
         if (digit_we) r_shadow[digit_sel] <= digit_in;
         if (w_commit) begin
            r_buf    <= r_shadow;
            r_dp_buf <= dp_in;
            r_lz_buf <= blank_lz;
         end
      end
   end

   // Current digit and every more-significant digit are zero
   always_comb begin
      w_upper_zero = 1'b1;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (i >= int'(r_digit) && r_buf[i] != '0) w_upper_zero = 1'b0;
      end
   end

   assign w_lz_blank = r_lz_buf && (r_digit != '0) && w_upper_zero;

   seg7_encode u_encode (
      .i_bcd   (r_buf[r_digit]),
      .i_blank (w_lz_blank),
      .o_seg_c (w_seg_c)
   );

   // Output registers lag the scan state by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_n      <= SEG_OFF;
         r_dp_n       <= 1'b1;
         r_an_n       <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_commit;
         if (r_state == DRIVE) begin
            r_seg_n <= w_seg_c;
            r_dp_n  <= ~r_dp_buf[r_digit];
            r_an_n  <= ~(N_DIGITS'(1) << r_digit);
         end else begin
            r_seg_n <= SEG_OFF;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
         end
      end
   end

   assign seg_n      = r_seg_n;
   assign dp_n       = r_dp_n;
   assign an_n       = r_an_n;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=8, DEAD=2 (frame = 32 cycles).
// Timeline: after reset release, the outputs seen after posedge k reflect
// internal slot tick k-1 (slot cycle (k-1)%8, digit ((k-1)/8)%4); commit
// happens on posedge 32, 64, ... and frame_done is high after those edges.
module tb_seg7_scan_driver;

   localparam int unsigned DIV  = 8;
   localparam int unsigned DEAD = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       digit_we;
   logic [1:0] digit_sel;
   logic [3:0] digit_in;
   logic [3:0] dp_in;
   logic       blank_lz;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [3:0] an_n;
   logic       frame_done;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_n       = 0;

   seg7_scan_driver #(.DIV(DIV), .DEAD(DEAD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit_we   (digit_we),
      .digit_sel  (digit_sel),
      .digit_in   (digit_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // One rising edge, then park on the following falling edge for sampling
   task automatic step();
      @(posedge clk);
      edge_n++;
      @(negedge clk);
   endtask

   task automatic run_to(input int k);
      while (edge_n < k) step();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      digit_we  = 1'b0;
      digit_sel = 2'd0;
      digit_in  = 4'd0;
      dp_in     = 4'd0;
      blank_lz  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
   endtask

   // Write lands on the next rising edge (edge_n + 1)
   task automatic wr(input logic [1:0] s, input logic [3:0] v);
      digit_sel = s;
      digit_in  = v;
      digit_we  = 1'b1;
      step();
      digit_we  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      run_to(5);
      tests_run++;
      if (an_n !== 4'b1110) begin
         tests_failed++;
         $display("FAIL reset_pre_drive an_n got %b exp %b", an_n, 4'b1110);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (an_n !== 4'b1111) begin
         tests_failed++;
         $display("FAIL reset_async an_n got %b exp %b", an_n, 4'b1111);
      end
      tests_run++;
      if (seg_n !== 7'h7F) begin
         tests_failed++;
         $display("FAIL reset_async seg_n got %b exp %b", seg_n, 7'h7F);
      end
      tests_run++;
      if (dp_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_async dp_n got %b exp 1", dp_n);
      end
      tests_run++;
      if (frame_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_async frame_done got %b exp 0", frame_done);
      end
   endtask

   task automatic test_first_frames();
      do_reset();
      wr(2'd0, 4'd1);
      wr(2'd1, 4'd2);
      wr(2'd2, 4'd3);
      wr(2'd3, 4'd4);
      run_to(27);
      tests_run++;
      if (an_n !== 4'b0111 || seg_n !== 7'b1000000) begin
         tests_failed++;
         $display("FAIL frame0_digit3 an_n/seg_n got %b/%b exp 0111/1000000", an_n, seg_n);
      end
      run_to(31);
      tests_run++;
      if (frame_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL frame_done_early got %b exp 0", frame_done);
      end
      run_to(32);
      tests_run++;
      if (frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL frame_done_pulse got %b exp 1", frame_done);
      end
      run_to(34);
      tests_run++;
      if (an_n !== 4'b1111 || seg_n !== 7'h7F) begin
         tests_failed++;
         $display("FAIL frame1_dead an_n/seg_n got %b/%b exp 1111/1111111", an_n, seg_n);
      end
      for (int k = 35; k <= 40; k++) begin
         run_to(k);
         tests_run++;
         if (an_n !== 4'b1110 || seg_n !== 7'b1111001) begin
            tests_failed++;
            $display("FAIL frame1_digit0 edge %0d an_n/seg_n got %b/%b exp 1110/1111001", k, an_n, seg_n);
         end
      end
      run_to(43);
      tests_run++;
      if (an_n !== 4'b1101 || seg_n !== 7'b0100100) begin
         tests_failed++;
         $display("FAIL frame1_digit1 an_n/seg_n got %b/%b exp 1101/0100100", an_n, seg_n);
      end
      run_to(59);
      tests_run++;
      if (an_n !== 4'b0111 || seg_n !== 7'b0011001) begin
         tests_failed++;
         $display("FAIL frame1_digit3 an_n/seg_n got %b/%b exp 0111/0011001", an_n, seg_n);
      end
   endtask

   task automatic test_commit_race();
      do_reset();
      run_to(31);
      wr(2'd2, 4'd7);
      run_to(51);
      tests_run++;
      if (an_n !== 4'b1011 || seg_n !== 7'b1000000) begin
         tests_failed++;
         $display("FAIL race_frame1 an_n/seg_n got %b/%b exp 1011/1000000", an_n, seg_n);
      end
      run_to(83);
      tests_run++;
      if (an_n !== 4'b1011 || seg_n !== 7'b1111000) begin
         tests_failed++;
         $display("FAIL race_frame2 an_n/seg_n got %b/%b exp 1011/1111000", an_n, seg_n);
      end
   endtask

   task automatic test_leading_zero();
      do_reset();
      blank_lz = 1'b1;
      dp_in    = 4'b1000;
      wr(2'd2, 4'd5);
      run_to(27);
      tests_run++;
      if (seg_n !== 7'b1000000 || dp_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL lz_uncommitted seg_n/dp_n got %b/%b exp 1000000/1", seg_n, dp_n);
      end
      run_to(35);
      tests_run++;
      if (an_n !== 4'b1110 || seg_n !== 7'b1000000 || dp_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL lz_digit0 an_n/seg_n/dp_n got %b/%b/%b exp 1110/1000000/1", an_n, seg_n, dp_n);
      end
      run_to(43);
      tests_run++;
      if (an_n !== 4'b1101 || seg_n !== 7'b1000000) begin
         tests_failed++;
         $display("FAIL lz_digit1 an_n/seg_n got %b/%b exp 1101/1000000", an_n, seg_n);
      end
      run_to(51);
      tests_run++;
      if (an_n !== 4'b1011 || seg_n !== 7'b0010010) begin
         tests_failed++;
         $display("FAIL lz_digit2 an_n/seg_n got %b/%b exp 1011/0010010", an_n, seg_n);
      end
      run_to(59);
      tests_run++;
      if (an_n !== 4'b0111 || seg_n !== 7'h7F || dp_n !== 1'b0) begin
         tests_failed++;
         $display("FAIL lz_digit3 an_n/seg_n/dp_n got %b/%b/%b exp 0111/1111111/0", an_n, seg_n, dp_n);
      end
   endtask

   task automatic test_dash();
      do_reset();
      wr(2'd1, 4'hC);
      wr(2'd0, 4'hF);
      run_to(35);
      tests_run++;
      if (an_n !== 4'b1110 || seg_n !== 7'b0111111) begin
         tests_failed++;
         $display("FAIL dash_digit0 an_n/seg_n got %b/%b exp 1110/0111111", an_n, seg_n);
      end
      run_to(43);
      tests_run++;
      if (an_n !== 4'b1101 || seg_n !== 7'b0111111) begin
         tests_failed++;
         $display("FAIL dash_digit1 an_n/seg_n got %b/%b exp 1101/0111111", an_n, seg_n);
      end
   endtask

   task automatic test_reset_mid_drive();
      do_reset();
      wr(2'd0, 4'd8);
      run_to(33);
      wr(2'd1, 4'd6);
      run_to(36);
      tests_run++;
      if (an_n !== 4'b1110 || seg_n !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL midrst_pre an_n/seg_n got %b/%b exp 1110/0000000", an_n, seg_n);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (an_n !== 4'b1111 || seg_n !== 7'h7F || dp_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_async an_n/seg_n/dp_n got %b/%b/%b exp 1111/1111111/1", an_n, seg_n, dp_n);
      end
      do_reset();
      for (int k = 1; k <= 2; k++) begin
         run_to(k);
         tests_run++;
         if (an_n !== 4'b1111 || seg_n !== 7'h7F) begin
            tests_failed++;
            $display("FAIL midrst_dead edge %0d an_n/seg_n got %b/%b exp 1111/1111111", k, an_n, seg_n);
         end
      end
      run_to(3);
      tests_run++;
      if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
         tests_failed++;
         $display("FAIL midrst_drive an_n/seg_n got %b/%b exp 1110/1000000", an_n, seg_n);
      end
      run_to(43);
      tests_run++;
      if (an_n !== 4'b1101 || seg_n !== 7'b1000000) begin
         tests_failed++;
         $display("FAIL midrst_discard an_n/seg_n got %b/%b exp 1101/1000000", an_n, seg_n);
      end
   endtask

   task automatic test_frames();
      int pulses;
      logic exp_fd;
      pulses = 0;
      do_reset();
      for (int k = 1; k <= 100; k++) begin
         step();
         exp_fd = (k == 32 || k == 64 || k == 96);
         if (frame_done === 1'b1) pulses++;
         tests_run++;
         if (frame_done !== exp_fd) begin
            tests_failed++;
            $display("FAIL frames_fd edge %0d got %b exp %b", k, frame_done, exp_fd);
         end
         tests_run++;
         if ($countones(~an_n) > 1) begin
            tests_failed++;
            $display("FAIL frames_onehot edge %0d an_n got %b exp at most one low", k, an_n);
         end
      end
      tests_run++;
      if (pulses != 3) begin
         tests_failed++;
         $display("FAIL frames_count got %0d exp 3", pulses);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      digit_we  = 1'b0;
      digit_sel = 2'd0;
      digit_in  = 4'd0;
      dp_in     = 4'd0;
      blank_lz  = 1'b0;
      test_reset();
      test_first_frames();
      test_commit_race();
      test_leading_zero();
      test_dash();
      test_reset_mid_drive();
      test_frames();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
